// File: rtl/fifo_stream_adapter.sv
// Read-side adapter: FIFO pop/empty/data with fixed read latency to a
// valid/ready stream, with credit-based pops into a small skid buffer.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = READ_LATENCY + 1,
  parameter int CNT_WIDTH    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [CNT_WIDTH-1:0]  level_o,
  output logic [CNT_WIDTH-1:0]  inflight_o
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
  localparam logic [CNT_WIDTH:0] DEPTH = (CNT_WIDTH + 1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNT_WIDTH-1:0]  level_q;
  logic [CNT_WIDTH-1:0]  inflight_q;
  logic [CNT_WIDTH-1:0]  level_nxt;
  logic [CNT_WIDTH:0]    used;
  logic                  valid_q;
  logic                  ret;
  logic                  wr_en;
  logic                  xfer;
  logic                  pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign xfer  = valid_q & m_ready_i;
  assign used  = {1'b0, level_q} + {1'b0, inflight_q}
               - (CNT_WIDTH + 1)'(xfer);
  // gated by reset so no pop escapes while held in reset
  assign pop   = rstn_i & ~fifo_empty_i & ~flush_i & (used < DEPTH);
  assign wr_en = ret & ~flush_i;

  assign level_nxt = level_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(xfer);

  generate
    if (READ_LATENCY == 0) begin : g_direct
      assign ret = pop;
    end else begin : g_tags
      logic [READ_LATENCY-1:0] tags;
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          tags <= '0;
        end else if (flush_i) begin
          tags <= '0;
        end else begin
          tags <= READ_LATENCY'({tags, pop});
        end
      end
      assign ret = tags[READ_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      level_q    <= '0;
      inflight_q <= '0;
      valid_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (flush_i) begin
      level_q    <= '0;
      inflight_q <= '0;
      valid_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      inflight_q <= inflight_q + CNT_WIDTH'(pop) - CNT_WIDTH'(ret);
      level_q    <= level_nxt;
      valid_q    <= (level_nxt != '0);
      if (wr_en) wr_ptr <= inc(wr_ptr);
      if (xfer)  rd_ptr <= inc(rd_ptr);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= fifo_data_i;
    end
  end

  assign fifo_pop_o = pop;
  assign m_valid_o  = valid_q;
  assign m_data_o   = mem[rd_ptr];
  assign level_o    = level_q;
  assign inflight_o = inflight_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(wr_en && !xfer && level_q == CNT_WIDTH'(BUF_DEPTH)));

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rstn_i)
    fifo_pop_o |-> !fifo_empty_i);

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: five instances (read latency 0..4)
// share one word source and are scored against a queue model.
module tb_fifo_stream_adapter;

  localparam int SRCN = 10100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic ready = 1'b0;
  bit   clr = 1'b0;
  int   src_avail = 0;
  int   cyc = 0;
  logic [31:0] src [SRCN];

  int n_tests = 0;
  int n_fail = 0;

  event ev_rst, ev_t1, ev_t2a, ev_t2b, ev_t3, ev_t4, ev_t6;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int RL = g;
    localparam int BD = g + 1;
    localparam int CW = $clog2(BD + 1);

    logic          fempty = 1'b1;
    logic          pop;
    logic          valid;
    logic [31:0]   fdata;
    logic [31:0]   mdata;
    logic [CW-1:0] level;
    logic [CW-1:0] inflight;
    logic [31:0]   hist [4];
    int            ridx = 0;
    bit            take = 0;
    bit            idle = 0;
    logic [31:0]   exp_q [$];
    logic [31:0]   hold_d = '0;
    bit            hold_v = 0;
    int npops = 0, nbeats = 0, gaps = 0, last_beat = 0;
    int first_pop = -1, first_val = -1, max_level = 0;

    fifo_stream_adapter #(
      .DATA_WIDTH  (32),
      .READ_LATENCY(RL)
    ) u_dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .flush_i     (flush),
      .fifo_empty_i(fempty),
      .fifo_pop_o  (pop),
      .fifo_data_i (fdata),
      .m_valid_o   (valid),
      .m_ready_i   (ready),
      .m_data_o    (mdata),
      .level_o     (level),
      .inflight_o  (inflight)
    );

    if (g == 0) begin : g_d0
      assign fdata = src[ridx % SRCN];
    end else begin : g_dn
      assign fdata = hist[g-1];
    end

    // source FIFO: the word popped at edge t shows up RL cycles later
    always @(posedge clk) begin
      #2;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = take ? src[ridx % SRCN] : $urandom;
      if (take) ridx++;
      fempty = (ridx >= src_avail);
    end

    always @(negedge clk) begin
      if (clr) begin
        npops = 0; nbeats = 0; gaps = 0; last_beat = 0;
        first_pop = -1; first_val = -1; max_level = 0;
      end
      if (!rstn) begin
        exp_q.delete();
        hold_v = 0;
        take = 0;
      end else begin
        check($sformatf("rl%0d_credit", RL),
              (int'(level) + int'(inflight)) <= BD, 1);
        check($sformatf("rl%0d_vld_lvl", RL), valid, level != 0);
        if (hold_v) begin
          check($sformatf("rl%0d_hold_v", RL), valid, 1);
          check($sformatf("rl%0d_hold_d", RL), mdata, hold_d);
        end
        if (valid && first_val < 0) first_val = cyc;
        if (int'(level) > max_level) max_level = int'(level);
        if (valid && ready) begin
          check($sformatf("rl%0d_beat_expected", RL), exp_q.size() != 0, 1);
          if (exp_q.size() != 0)
            check($sformatf("rl%0d_data", RL), mdata, exp_q.pop_front());
          if (nbeats > 0 && cyc != last_beat + 1) gaps++;
          last_beat = cyc;
          nbeats++;
        end
        if (flush) begin
          check($sformatf("rl%0d_pop_in_flush", RL), pop, 0);
          exp_q.delete();
        end
        if (pop) begin
          check($sformatf("rl%0d_pop_nonempty", RL), ridx < src_avail, 1);
          exp_q.push_back(src[ridx % SRCN]);
          npops++;
          if (first_pop < 0) first_pop = cyc;
        end
        take = pop;
        hold_v = valid && !ready && !flush;
        hold_d = mdata;
      end
      idle = (ridx == src_avail) && (exp_q.size() == 0) &&
             (level == 0) && (inflight == 0) && !valid;
    end

    always @(ev_rst) begin
      check($sformatf("rl%0d_rst_valid", RL), valid, 0);
      check($sformatf("rl%0d_rst_pop", RL), pop, 0);
      check($sformatf("rl%0d_rst_level", RL), level, 0);
      check($sformatf("rl%0d_rst_inflight", RL), inflight, 0);
      check($sformatf("rl%0d_rst_data", RL), mdata, 0);
    end

    always @(ev_t1) begin
      check($sformatf("rl%0d_t1_latency", RL), first_val - first_pop, RL + 1);
      check($sformatf("rl%0d_t1_beats", RL), nbeats, 8);
      check($sformatf("rl%0d_t1_gaps", RL), gaps, 0);
    end

    always @(ev_t2a) begin
      check($sformatf("rl%0d_t2_pops", RL), npops, BD);
      check($sformatf("rl%0d_t2_level", RL), level, BD);
      check($sformatf("rl%0d_t2_inflight", RL), inflight, 0);
      check($sformatf("rl%0d_t2_valid", RL), valid, 1);
    end

    always @(ev_t2b) check($sformatf("rl%0d_t2_beats", RL), nbeats, 5);

    always @(ev_t3) begin
      check($sformatf("rl%0d_t3_beats", RL), nbeats, 16);
      check($sformatf("rl%0d_t3_maxlvl", RL), max_level <= BD, 1);
    end

    always @(ev_t6) check($sformatf("rl%0d_t6_beats", RL), nbeats, 10000);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done;
    ready = 1'b1;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step(1);
      done = g_dut[0].idle && g_dut[1].idle && g_dut[2].idle &&
             g_dut[3].idle && g_dut[4].idle;
    end
    check(tag, done, 1);
    step(2);
  endtask

  task automatic start(input int words, input logic rdy);
    step(1);
    clr = 1'b1;
    ready = rdy;
    src_avail += words;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    bit found;
    int added;
    for (int i = 0; i < SRCN; i++) src[i] = $urandom;

    step(2);
    -> ev_rst;
    step(1);
    rstn = 1'b1;
    step(2);

    // T1: eight words, consumer always ready
    start(8, 1'b1);
    step(25);
    -> ev_t1;
    drain("t1_drain");

    // T2: consumer stalled with five words available
    start(5, 1'b0);
    step(12);
    -> ev_t2a;
    ready = 1'b1;
    step(30);
    -> ev_t2b;
    drain("t2_drain");

    // T3: ready toggling every cycle
    start(16, 1'b1);
    for (int i = 0; i < 60; i++) begin
      ready = ~ready;
      step(1);
    end
    -> ev_t3;
    drain("t3_drain");

    // T4: flush while latency-3 instance holds two words and two in flight
    start(8, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (g_dut[3].level == 2 && g_dut[3].inflight == 2) found = 1;
      else step(1);
    end
    check("t4_setup", found, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("t4_valid", g_dut[3].valid, 0);
    check("t4_level", g_dut[3].level, 0);
    check("t4_inflight", g_dut[3].inflight, 0);
    drain("t4_drain");
    check("t4_beats", g_dut[3].nbeats, 4);

    // T5: reset asserted between clock edges mid-burst
    start(20, 1'b1);
    step(5);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    -> ev_rst;
    step(3);
    rstn = 1'b1;
    drain("t5_drain");

    // T6: random empty/ready, ten thousand words
    start(0, 1'b1);
    added = 0;
    while (added < 10000) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        src_avail++;
        added++;
      end
      step(1);
    end
    drain("t6_drain");
    -> ev_t6;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
